// File: rtl/program_counter_ras.sv
// LEGv8 fetch-stage program counter with stall, call/return and a circular return-address stack.
// PC is registered; PC4 and the RAS status flags are derived combinationally from registered state.
module program_counter_ras #(
    parameter int            N            = 64,
    parameter int            RAS_DEPTH    = 4,
    parameter logic [N-1:0]  RESET_VECTOR = '0
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         stall,
    input  logic [2:0]   PS,
    input  logic [N-1:0] in,
    output logic [N-1:0] PC,
    output logic [N-1:0] PC4,
    output logic         ras_empty,
    output logic         ras_full,
    output logic         ras_ovf,
    output logic         ras_unf
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = $clog2(RAS_DEPTH + 1);

    localparam logic [CW-1:0] C_DEPTH = CW'(RAS_DEPTH);
    localparam logic [CW-1:0] C_ONE   = CW'(1);
    localparam logic [PW-1:0] P_ONE   = PW'(1);

    typedef enum logic [2:0] {
        PS_HOLD  = 3'b000,
        PS_SEQ   = 3'b001,
        PS_ABS   = 3'b010,
        PS_REL   = 3'b011,
        PS_RSV4  = 3'b100,
        PS_CALL  = 3'b101,
        PS_RET   = 3'b110,
        PS_RSV7  = 3'b111
    } ps_t;

    logic [N-1:0]  r_pc;
    logic [PW-1:0] r_top;
    logic [CW-1:0] r_count;
    logic          r_ovf;
    logic          r_unf;
    logic [N-1:0]  r_ras [RAS_DEPTH];

    ps_t           w_ps;
    logic [N-1:0]  w_pc4;
    logic [N-1:0]  w_off;
    logic [N-1:0]  w_align_in;
    logic          w_empty;
    logic          w_full;
    logic [N-1:0]  w_pc_next;
    logic [PW-1:0] w_top_next;
    logic [CW-1:0] w_count_next;
    logic          w_ovf_next;
    logic          w_unf_next;
    logic          w_push;

    assign w_ps       = ps_t'(PS);
    assign w_pc4      = r_pc + N'(4);
    assign w_off      = {in[N-3:0], 2'b00};
    assign w_align_in = {in[N-1:2], 2'b00};
    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == C_DEPTH);

    // NOTE: every output of this block gets a default first, so no path through the case can infer a latch.
    always_comb begin
        w_pc_next    = r_pc;
        w_top_next   = r_top;
        w_count_next = r_count;
        w_ovf_next   = r_ovf;
        w_unf_next   = r_unf;
        w_push       = 1'b0;
        if (!stall) begin
            case (w_ps)
                PS_SEQ:  w_pc_next = w_pc4;
                PS_ABS:  w_pc_next = w_align_in;
                PS_REL:  w_pc_next = r_pc + w_off;
                PS_CALL: begin
                    w_pc_next  = r_pc + w_off;
                    w_push     = 1'b1;
                    w_top_next = r_top + P_ONE;
                    // A full stack overwrites its oldest entry, which is the slot just past the top.
                    if (w_full) w_ovf_next   = 1'b1;
                    else        w_count_next = r_count + C_ONE;
                end
                PS_RET: begin
                    if (!w_empty) begin
                        w_pc_next    = r_ras[r_top];
                        w_top_next   = r_top - P_ONE;
                        w_count_next = r_count - C_ONE;
                    end else begin
                        w_pc_next  = w_align_in;
                        w_unf_next = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pc    <= RESET_VECTOR;
            r_top   <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_pc    <= w_pc_next;
            r_top   <= w_top_next;
            r_count <= w_count_next;
            r_ovf   <= w_ovf_next;
            r_unf   <= w_unf_next;
        end
    end

    // NOTE: stack entries are not reset; a zero count guarantees no stale entry is ever read.
    always_ff @(posedge clock) begin
        if (reset && w_push) r_ras[w_top_next] <= w_pc4;
    end

    assign PC        = r_pc;
    assign PC4       = w_pc4;
    assign ras_empty = w_empty;
    assign ras_full  = w_full;
    assign ras_ovf   = r_ovf;
    assign ras_unf   = r_unf;

endmodule
